armv8_ctrl_pipe: RTL and testbench
==================================

Name: armv8_ctrl_pipe

Overview:
- Downstream end of the control-unit interface: takes the decoded control bundle the control unit produces in ID and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Adds load-use hazard detection, which stalls by inserting a bubble.
- Adds a branch-taken flush.
- Adds saturating retired-instruction and bubble counters.
- Sits between the ID-stage control unit and the EX/MEM/WB datapath of the segmented ARMv8 core.

Parameters:
CNT_W, 16, width of retired_cnt and bubble_cnt
ZR, 31, register index of XZR; never a hazard source

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
id_valid  input  1  ID holds a real instruction
id_alusrc  input  1  ALUSrc from control unit
id_aluop  input  3  ALUOp from control unit
id_branch  input  1  Branch from control unit
id_memread  input  1  MemRead from control unit
id_memwrite  input  1  MemWrite from control unit
id_memtoreg  input  1  MemtoReg from control unit
id_regwrite  input  1  RegWrite from control unit
id_rn  input  5  first source register
id_rm  input  5  second source register (Rm or Rt, per Reg2Loc)
id_uses_rm  input  1  second source is actually read
id_rd  input  5  destination register
mem_branch_taken  input  1  branch in MEM resolved taken
hazard_stall  output  1  load-use stall; IF and ID hold
ex_valid, ex_alusrc, ex_aluop[2:0], ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_rd[4:0]  output  ID/EX register
mem_valid, mem_branch, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_rd[4:0]  output  EX/MEM register
wb_valid, wb_memtoreg, wb_regwrite, wb_rd[4:0]  output  MEM/WB register
retired_cnt  output  CNT_W  instructions leaving WB
bubble_cnt  output  CNT_W  bubbles inserted

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-stream):
  - all *_valid=0 and all control bits=0.
  - all *_rd=ZR.
  - both counters=0.
  - hazard_stall follows its combinational equation, which evaluates to 0 because ex_valid=0.
- Bubble definition: valid=0, every control bit 0, aluop=000, rd=ZR. Each stage's registered outputs are therefore 0 whenever that stage is invalid.
- hazard_stall (combinational) = id_valid & ex_valid & ex_memread & (ex_rd!=ZR) & ((ex_rd==id_rn) | (id_uses_rm & ex_rd==id_rm)).
- Each edge, priority order:
  1. mem_branch_taken=1: ID/EX and EX/MEM load bubbles. MEM/WB loads the MEM stage (the branch) normally. Stall is ignored.
  2. else hazard_stall=1: ID/EX loads a bubble. EX/MEM and MEM/WB advance normally.
  3. else: ID/EX loads the ID bundle if id_valid, otherwise a bubble. EX/MEM and MEM/WB advance.
- Latency: exactly 1 cycle per stage. An ID bundle appears at EX after edge 1, at MEM after edge 2, at WB after edge 3.
- retired_cnt: +1 on each edge where wb_valid=1 before the edge.
- bubble_cnt increment per edge:
  - +2 on flush, independent of stall.
  - +1 on stall without flush.
  - 0 otherwise.
  - id_valid=0 bubbles are not counted.
- Both counters saturate at 2^CNT_W-1. A +2 from max-1 yields max, never wraps.
- Stall persists as long as the condition holds. No internal timeout or state beyond the pipeline registers and counters.

Test Plan:
- Reset with a full pipeline: rst_n low mid-cycle -> all valid/control outputs 0 and rd=31 immediately, without waiting for a clock edge; counters 0.
- ADD bundle (aluop=010, regwrite=1, rd=5, id_valid=1 for one cycle) -> ex_* after edge 1, mem_* after edge 2, wb_regwrite=1 and wb_rd=5 after edge 3; retired_cnt=1 after edge 4; bubble_cnt=0.
- LDUR in EX (ex_memread=1, ex_rd=3) with ID rn=3 -> hazard_stall=1; after the edge ex_valid=0 and ex_regwrite=0, mem_memread=1, mem_rd=3, bubble_cnt=1. The same case with id_rm=3 and id_uses_rm=0 -> no stall.
- LDUR with ex_rd=31 and id_rn=31 -> hazard_stall=0; bundle advances into EX.
- mem_branch_taken=1 while hazard_stall=1 -> after the edge ex_valid=0 and mem_valid=0, wb_valid=1 (branch, wb_regwrite=0), bubble_cnt +=2.
- CNT_W=4, bubble_cnt=14, flush -> 15; another flush -> 15. With 20 consecutive valid retirements -> retired_cnt holds at 15.

Source files
------------

// File: rtl/armv8_ctrl_pipe.sv
// Control-bundle pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall, branch flush
// and saturating retired/bubble counters for the segmented ARMv8 core.
module armv8_ctrl_pipe #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ZR    = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_alusrc,
    input  logic [2:0]       id_aluop,
    input  logic             id_branch,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             id_regwrite,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic [4:0]       id_rd,
    input  logic             mem_branch_taken,
    output logic             hazard_stall,
    output logic             ex_valid,
    output logic             ex_alusrc,
    output logic [2:0]       ex_aluop,
    output logic             ex_branch,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_regwrite,
    output logic [4:0]       ex_rd,
    output logic             mem_valid,
    output logic             mem_branch,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             mem_memtoreg,
    output logic             mem_regwrite,
    output logic [4:0]       mem_rd,
    output logic             wb_valid,
    output logic             wb_memtoreg,
    output logic             wb_regwrite,
    output logic [4:0]       wb_rd,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [4:0] RZ = 5'(ZR);

    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic [2:0] aluop;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] rd;
    } ex_t;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] rd;
    } mem_t;

    typedef struct packed {
        logic       valid;
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] rd;
    } wb_t;

    localparam ex_t  ExBubble  = {10'd0, RZ};
    localparam mem_t MemBubble = {6'd0, RZ};
    localparam wb_t  WbBubble  = {3'd0, RZ};

    ex_t              r_ex, w_ex_d;
    mem_t             r_mem, w_mem_d;
    wb_t              r_wb, w_wb_d;
    logic [CNT_W-1:0] r_retired_cnt, r_bubble_cnt;
    logic [1:0]       w_bub_inc;
    logic [CNT_W:0]   w_bub_sum;
    logic             w_stall;

    assign w_stall = id_valid & r_ex.valid & r_ex.memread & (r_ex.rd != RZ) &
                     ((r_ex.rd == id_rn) | (id_uses_rm & (r_ex.rd == id_rm)));

    always_comb begin
        w_ex_d = ExBubble;
        if (!mem_branch_taken && !w_stall && id_valid) begin
            w_ex_d = {1'b1, id_alusrc, id_aluop, id_branch, id_memread, id_memwrite,
                      id_memtoreg, id_regwrite, id_rd};
        end
        w_mem_d = MemBubble;
        if (!mem_branch_taken) begin
            w_mem_d = {r_ex.valid, r_ex.branch, r_ex.memread, r_ex.memwrite,
                       r_ex.memtoreg, r_ex.regwrite, r_ex.rd};
        end
        // The branch itself sits in MEM and always retires, even when it flushes.
        w_wb_d = {r_mem.valid, r_mem.memtoreg, r_mem.regwrite, r_mem.rd};
    end

    always_comb begin
        w_bub_inc = 2'd0;
        if (mem_branch_taken) begin
            w_bub_inc = 2'd2;
        end else if (w_stall) begin
            w_bub_inc = 2'd1;
        end
        w_bub_sum = {1'b0, r_bubble_cnt} + {{(CNT_W-1){1'b0}}, w_bub_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex          <= ExBubble;
            r_mem         <= MemBubble;
            r_wb          <= WbBubble;
            r_retired_cnt <= '0;
            r_bubble_cnt  <= '0;
        end else begin
            r_ex  <= w_ex_d;
            r_mem <= w_mem_d;
            r_wb  <= w_wb_d;
            if (r_wb.valid && (r_retired_cnt != {CNT_W{1'b1}})) begin
                r_retired_cnt <= r_retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // Carry out of the widened sum means the add crossed the max value.
            r_bubble_cnt <= w_bub_sum[CNT_W] ? {CNT_W{1'b1}} : w_bub_sum[CNT_W-1:0];
        end
    end

    assign hazard_stall = w_stall;
    assign ex_valid     = r_ex.valid;
    assign ex_alusrc    = r_ex.alusrc;
    assign ex_aluop     = r_ex.aluop;
    assign ex_branch    = r_ex.branch;
    assign ex_memread   = r_ex.memread;
    assign ex_memwrite  = r_ex.memwrite;
    assign ex_memtoreg  = r_ex.memtoreg;
    assign ex_regwrite  = r_ex.regwrite;
    assign ex_rd        = r_ex.rd;
    assign mem_valid    = r_mem.valid;
    assign mem_branch   = r_mem.branch;
    assign mem_memread  = r_mem.memread;
    assign mem_memwrite = r_mem.memwrite;
    assign mem_memtoreg = r_mem.memtoreg;
    assign mem_regwrite = r_mem.regwrite;
    assign mem_rd       = r_mem.rd;
    assign wb_valid     = r_wb.valid;
    assign wb_memtoreg  = r_wb.memtoreg;
    assign wb_regwrite  = r_wb.regwrite;
    assign wb_rd        = r_wb.rd;
    assign retired_cnt  = r_retired_cnt;
    assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_armv8_ctrl_pipe.sv
// Bench for armv8_ctrl_pipe: directed scenario tasks plus a WB-retirement scoreboard;
// a second CNT_W=4 instance shares the stimulus for the saturation scenario.
module tb_armv8_ctrl_pipe;

    logic        clk, rst_n;
    logic        id_valid, id_alusrc, id_branch, id_memread, id_memwrite, id_memtoreg;
    logic        id_regwrite, id_uses_rm, mem_branch_taken;
    logic [2:0]  id_aluop;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic        hazard_stall;
    logic        ex_valid, ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg;
    logic        ex_regwrite;
    logic [2:0]  ex_aluop;
    logic [4:0]  ex_rd;
    logic        mem_valid, mem_branch, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
    logic [4:0]  mem_rd;
    logic        wb_valid, wb_memtoreg, wb_regwrite;
    logic [4:0]  wb_rd;
    logic [15:0] retired_cnt, bubble_cnt;
    logic [3:0]  retired_cnt4, bubble_cnt4;

    // Outputs of the narrow-counter instance that the bench does not inspect.
    logic        s_hz, s_exv, s_exa, s_exb, s_exmr, s_exmw, s_exmt, s_exrw;
    logic [2:0]  s_exop;
    logic [4:0]  s_exrd, s_mrd, s_wrd;
    logic        s_mv, s_mb, s_mmr, s_mmw, s_mmt, s_mrw, s_wv, s_wmt, s_wrw;

    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
        logic       mtr;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    bit   sb_en;
    int   total, bad;

    armv8_ctrl_pipe #(.CNT_W(16), .ZR(31)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alusrc(id_alusrc),
        .id_aluop(id_aluop), .id_branch(id_branch), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
        .mem_branch_taken(mem_branch_taken), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
        .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_branch(mem_branch), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .wb_valid(wb_valid),
        .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt)
    );

    armv8_ctrl_pipe #(.CNT_W(4), .ZR(31)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alusrc(id_alusrc),
        .id_aluop(id_aluop), .id_branch(id_branch), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
        .mem_branch_taken(mem_branch_taken), .hazard_stall(s_hz),
        .ex_valid(s_exv), .ex_alusrc(s_exa), .ex_aluop(s_exop),
        .ex_branch(s_exb), .ex_memread(s_exmr), .ex_memwrite(s_exmw),
        .ex_memtoreg(s_exmt), .ex_regwrite(s_exrw), .ex_rd(s_exrd),
        .mem_valid(s_mv), .mem_branch(s_mb), .mem_memread(s_mmr),
        .mem_memwrite(s_mmw), .mem_memtoreg(s_mmt),
        .mem_regwrite(s_mrw), .mem_rd(s_mrd), .wb_valid(s_wv),
        .wb_memtoreg(s_wmt), .wb_regwrite(s_wrw), .wb_rd(s_wrd),
        .retired_cnt(retired_cnt4), .bubble_cnt(bubble_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every WB-valid cycle must match the oldest pushed instruction.
    always @(negedge clk) begin
        if (sb_en && rst_n && wb_valid) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got retirement rd=%0d, required none", wb_rd);
            end else begin
                mon_e = sbq.pop_front();
                if ({wb_rd, wb_regwrite, wb_memtoreg} !== {mon_e.rd, mon_e.rw, mon_e.mtr}) begin
                    bad++;
                    $display("FAIL sb_wb: got rd=%0d rw=%0b mtr=%0b, required rd=%0d rw=%0b mtr=%0b",
                             wb_rd, wb_regwrite, wb_memtoreg, mon_e.rd, mon_e.rw, mon_e.mtr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_alusrc = 0; id_aluop = 3'b000; id_branch = 0; id_memread = 0;
        id_memwrite = 0; id_memtoreg = 0; id_regwrite = 0; id_rn = 0; id_rm = 0;
        id_uses_rm = 0; id_rd = 0;
    endtask

    task automatic drive_id(input logic mr, input logic rw, input logic mtr, input logic br,
                            input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                            input logic [4:0] rm, input logic urm);
        id_valid = 1; id_alusrc = mr; id_aluop = op; id_branch = br; id_memread = mr;
        id_memwrite = 0; id_memtoreg = mtr; id_regwrite = rw; id_rd = rd; id_rn = rn;
        id_rm = rm; id_uses_rm = urm;
    endtask

    task automatic do_reset();
        clear_id();
        mem_branch_taken = 0;
        @(negedge clk) rst_n = 0;
        @(negedge clk) rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_id(0, 1, 0, 0, 3'b010, 5'd5, 5'd1, 5'd2, 1);
            tick();
        end
        #2 rst_n = 0;
        #1;
        total++;
        if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin
            bad++; $display("FAIL rst_valid: got %b, required 000", {ex_valid, mem_valid, wb_valid});
        end
        total++;
        if ({ex_rd, mem_rd, wb_rd} !== {5'd31, 5'd31, 5'd31}) begin
            bad++; $display("FAIL rst_rd: got %0d/%0d/%0d, required 31/31/31", ex_rd, mem_rd, wb_rd);
        end
        total++;
        if ({ex_regwrite, ex_aluop, mem_regwrite, wb_regwrite} !== 6'b0) begin
            bad++; $display("FAIL rst_ctrl: got %b, required 000000",
                            {ex_regwrite, ex_aluop, mem_regwrite, wb_regwrite});
        end
        total++;
        if (retired_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
            bad++; $display("FAIL rst_cnt: got %0d/%0d, required 0/0", retired_cnt, bubble_cnt);
        end
        total++;
        if (hazard_stall !== 1'b0) begin
            bad++; $display("FAIL rst_stall: got %b, required 0", hazard_stall);
        end
        clear_id();
        @(negedge clk) rst_n = 1;
        tick();
    endtask

    task automatic test_add();
        do_reset();
        sb_en = 1;
        drive_id(0, 1, 0, 0, 3'b010, 5'd5, 5'd1, 5'd2, 1);
        sbq.push_back('{rd: 5'd5, rw: 1'b1, mtr: 1'b0});
        tick();
        clear_id();
        total++;
        if ({ex_valid, ex_aluop, ex_regwrite, ex_rd} !== {1'b1, 3'b010, 1'b1, 5'd5}) begin
            bad++; $display("FAIL add_ex: got v=%b op=%b rw=%b rd=%0d, required 1 010 1 5",
                            ex_valid, ex_aluop, ex_regwrite, ex_rd);
        end
        tick();
        total++;
        if ({mem_valid, mem_regwrite, mem_rd, ex_valid} !== {1'b1, 1'b1, 5'd5, 1'b0}) begin
            bad++; $display("FAIL add_mem: got v=%b rw=%b rd=%0d exv=%b, required 1 1 5 0",
                            mem_valid, mem_regwrite, mem_rd, ex_valid);
        end
        tick();
        total++;
        if ({wb_valid, wb_regwrite, wb_rd, retired_cnt} !== {1'b1, 1'b1, 5'd5, 16'd0}) begin
            bad++; $display("FAIL add_wb: got v=%b rw=%b rd=%0d ret=%0d, required 1 1 5 0",
                            wb_valid, wb_regwrite, wb_rd, retired_cnt);
        end
        tick();
        total++;
        if (retired_cnt !== 16'd1 || bubble_cnt !== 16'd0) begin
            bad++; $display("FAIL add_cnt: got ret=%0d bub=%0d, required 1 0", retired_cnt, bubble_cnt);
        end
        total++;
        if (sbq.size() != 0) begin
            bad++; $display("FAIL add_sb_left: got %0d pending, required 0", sbq.size());
        end
        sb_en = 0;
        sbq.delete();
    endtask

    task automatic test_hazard();
        do_reset();
        drive_id(1, 1, 1, 0, 3'b000, 5'd3, 5'd1, 5'd0, 0);
        tick();
        drive_id(0, 1, 0, 0, 3'b010, 5'd7, 5'd3, 5'd4, 1);
        #1;
        total++;
        if (hazard_stall !== 1'b1) begin
            bad++; $display("FAIL hz_rn: got stall=%b, required 1", hazard_stall);
        end
        tick();
        total++;
        if ({ex_valid, ex_regwrite, mem_memread, mem_rd, bubble_cnt} !==
            {1'b0, 1'b0, 1'b1, 5'd3, 16'd1}) begin
            bad++; $display("FAIL hz_bubble: got exv=%b exrw=%b mmr=%b mrd=%0d bub=%0d, required 0 0 1 3 1",
                            ex_valid, ex_regwrite, mem_memread, mem_rd, bubble_cnt);
        end
        tick();
        clear_id();
        total++;
        if ({ex_valid, ex_rd} !== {1'b1, 5'd7}) begin
            bad++; $display("FAIL hz_resume: got exv=%b rd=%0d, required 1 7", ex_valid, ex_rd);
        end
        // Rm matches the load but is not read: no stall unless uses_rm is set.
        do_reset();
        drive_id(1, 1, 1, 0, 3'b000, 5'd3, 5'd1, 5'd0, 0);
        tick();
        drive_id(0, 1, 0, 0, 3'b010, 5'd8, 5'd1, 5'd3, 1);
        #1;
        total++;
        if (hazard_stall !== 1'b1) begin
            bad++; $display("FAIL hz_rm_used: got stall=%b, required 1", hazard_stall);
        end
        id_uses_rm = 0;
        #1;
        total++;
        if (hazard_stall !== 1'b0) begin
            bad++; $display("FAIL hz_rm_unused: got stall=%b, required 0", hazard_stall);
        end
        tick();
        clear_id();
        total++;
        if ({ex_valid, ex_rd, bubble_cnt} !== {1'b1, 5'd8, 16'd0}) begin
            bad++; $display("FAIL hz_rm_adv: got exv=%b rd=%0d bub=%0d, required 1 8 0",
                            ex_valid, ex_rd, bubble_cnt);
        end
    endtask

    task automatic test_zr();
        do_reset();
        drive_id(1, 1, 1, 0, 3'b000, 5'd31, 5'd1, 5'd0, 0);
        tick();
        drive_id(0, 1, 0, 0, 3'b010, 5'd9, 5'd31, 5'd31, 1);
        #1;
        total++;
        if (hazard_stall !== 1'b0) begin
            bad++; $display("FAIL zr_stall: got stall=%b, required 0", hazard_stall);
        end
        tick();
        clear_id();
        total++;
        if ({ex_valid, ex_rd, bubble_cnt} !== {1'b1, 5'd9, 16'd0}) begin
            bad++; $display("FAIL zr_adv: got exv=%b rd=%0d bub=%0d, required 1 9 0",
                            ex_valid, ex_rd, bubble_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive_id(0, 0, 0, 1, 3'b001, 5'd31, 5'd2, 5'd0, 0);
        tick();
        drive_id(1, 1, 1, 0, 3'b000, 5'd3, 5'd1, 5'd0, 0);
        tick();
        drive_id(0, 1, 0, 0, 3'b010, 5'd6, 5'd3, 5'd0, 0);
        #1;
        total++;
        if ({hazard_stall, mem_valid, mem_branch} !== 3'b111) begin
            bad++; $display("FAIL fl_setup: got stall=%b mv=%b mb=%b, required 111",
                            hazard_stall, mem_valid, mem_branch);
        end
        mem_branch_taken = 1;
        tick();
        mem_branch_taken = 0;
        clear_id();
        total++;
        if ({ex_valid, mem_valid, wb_valid, wb_regwrite, bubble_cnt} !==
            {1'b0, 1'b0, 1'b1, 1'b0, 16'd2}) begin
            bad++; $display("FAIL fl_result: got exv=%b mv=%b wv=%b wrw=%b bub=%0d, required 0 0 1 0 2",
                            ex_valid, mem_valid, wb_valid, wb_regwrite, bubble_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic       ld;
        logic       rw;
        logic [4:0] rd;
        do_reset();
        sb_en = 1;
        // Loads write r16..r30 and sources come from r0..r15, so nothing stalls.
        for (int i = 0; i < 12; i++) begin
            ld = 1'($urandom_range(0, 1));
            rw = ld ? 1'b1 : 1'($urandom_range(0, 1));
            rd = ld ? 5'(16 + $urandom_range(0, 14)) : 5'($urandom_range(0, 31));
            drive_id(ld, rw, ld, 0, ld ? 3'b000 : 3'b010, rd, 5'($urandom_range(0, 15)),
                     5'($urandom_range(0, 15)), 1);
            sbq.push_back('{rd: rd, rw: rw, mtr: ld});
            tick();
        end
        clear_id();
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (sbq.size() != 0) begin
            bad++; $display("FAIL b2b_sb_left: got %0d pending, required 0", sbq.size());
        end
        total++;
        if (retired_cnt !== 16'd12 || bubble_cnt !== 16'd0) begin
            bad++; $display("FAIL b2b_cnt: got ret=%0d bub=%0d, required 12 0", retired_cnt, bubble_cnt);
        end
        sb_en = 0;
        sbq.delete();
    endtask

    task automatic test_saturation();
        do_reset();
        mem_branch_taken = 1;
        for (int i = 0; i < 7; i++) tick();
        total++;
        if (bubble_cnt4 !== 4'd14) begin
            bad++; $display("FAIL sat_b14: got %0d, required 14", bubble_cnt4);
        end
        tick();
        total++;
        if (bubble_cnt4 !== 4'd15) begin
            bad++; $display("FAIL sat_b15: got %0d, required 15", bubble_cnt4);
        end
        tick();
        total++;
        if (bubble_cnt4 !== 4'd15 || bubble_cnt !== 16'd18) begin
            bad++; $display("FAIL sat_bhold: got %0d (wide %0d), required 15 (wide 18)",
                            bubble_cnt4, bubble_cnt);
        end
        mem_branch_taken = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_id(0, 1, 0, 0, 3'b010, 5'd1, 5'd2, 5'd3, 1);
            tick();
        end
        clear_id();
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (retired_cnt4 !== 4'd15 || retired_cnt !== 16'd20) begin
            bad++; $display("FAIL sat_ret: got %0d (wide %0d), required 15 (wide 20)",
                            retired_cnt4, retired_cnt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sb_en = 0;
        rst_n = 0;
        mem_branch_taken = 0;
        clear_id();
        test_reset();
        test_add();
        test_hazard();
        test_zr();
        test_flush();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
